// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared encodings and helpers for the multi-channel PWM generator.
//   - MODE_EDGE / MODE_CENTER : counter alignment mode.
//   - DIR_UP / DIR_DOWN       : counter direction encoding.
//   - duty_lsb()              : LSB position of a channel's duty in a packed bus.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Channel ch occupies bits [ch*width +: width] of a packed duty bus.
  function automatic int duty_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage : pwm_pkg

// File: rtl/pwm_counter.sv
// -----------------------------------------------------------------------------
// pwm_counter
//   Shared period counter for the PWM block. Counts 0..P and wraps (edge mode)
//   or 0..P..0 (centre mode, period 2P). With P == 0 the count stays at 0 and
//   every cycle is a period boundary.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   en_i          : run enable; low holds cnt at 0 with dir up
//   period_i      : active period P
//   mode_i        : active mode (MODE_EDGE / MODE_CENTER)
//   cnt_o         : current count
//   dir_o         : current direction (DIR_UP / DIR_DOWN)
//   wrap_o        : the coming edge returns the count to 0 at a period boundary
//                   (also high while en_i is low, so pending updates can load)
//   cycle_start_o : first cycle of a period
// -----------------------------------------------------------------------------
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             dir_o,
  output logic             wrap_o,
  output logic             cycle_start_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             period_zero;

  assign cnt_inc     = cnt_q + ONE;
  assign cnt_dec     = cnt_q - ONE;
  assign period_zero = (period_i == '0);

  // Direction is updated on arrival: it reads DIR_DOWN while cnt sits at P
  // and DIR_UP again once cnt reaches 0, so cnt == 0 always pairs with DIR_UP.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers latches.
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    wrap_o = 1'b0;

    if (!en_i || period_zero) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      wrap_o = 1'b1;
    end else if (mode_i == MODE_EDGE) begin
      dir_d = DIR_UP;
      if (cnt_q == period_i) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (dir_q == DIR_UP) begin
      cnt_d = cnt_inc;
      if (cnt_inc == period_i) begin
        dir_d = DIR_DOWN;
      end
    end else begin
      cnt_d = cnt_dec;
      if (cnt_q == ONE) begin
        dir_d  = DIR_UP;
        wrap_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt_o = cnt_q;
  assign dir_o = dir_q;

  // Gated by rst so the boundary flag stays low while reset is held, even
  // though cnt already reads 0 then.
  assign cycle_start_o = rst & en_i & (cnt_q == '0) & ((dir_q == DIR_UP) | period_zero);

endmodule : pwm_counter

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//   Multi-channel PWM generator. One shared period counter drives CHANNELS
//   duty comparators. Period, mode and duties are written through a
//   valid/ready port into shadow registers and only become active at a period
//   boundary, so an update never produces a partial pulse.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   en          : run enable; low holds the counter and forces outputs low
//   upd_valid   : update request
//   upd_ready   : update accepted when high together with upd_valid
//   upd_period  : new period P
//   upd_mode    : new mode (0 = edge, 1 = centre)
//   upd_duty    : new duties, channel i at [i*WIDTH +: WIDTH]
//   pwm_out     : PWM outputs
//   cycle_start : high in the first cycle of each period
//   duty_active : currently applied duties, same packing as upd_duty
// -----------------------------------------------------------------------------
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [WIDTH-1:0]          upd_period,
  input  logic                      upd_mode,
  input  logic [CHANNELS*WIDTH-1:0] upd_duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      cycle_start,
  output logic [CHANNELS*WIDTH-1:0] duty_active
);

  localparam int DW = CHANNELS * WIDTH;

  // Shadow (written by the handshake) and active (used by the counter and
  // comparators) copies of the configuration.
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] shd_period_q, shd_period_d;
  logic             shd_mode_q, shd_mode_d;
  logic [DW-1:0]    shd_duty_q, shd_duty_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic             act_mode_q, act_mode_d;
  logic [DW-1:0]    act_duty_q, act_duty_d;

  logic [WIDTH-1:0] cnt;
  logic             cnt_dir;
  logic             wrap;
  logic             accept;
  logic             load;

  pwm_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .period_i      (act_period_q),
    .mode_i        (act_mode_q),
    .cnt_o         (cnt),
    .dir_o         (cnt_dir),
    .wrap_o        (wrap),
    .cycle_start_o (cycle_start)
  );

  // accept needs pending low and load needs it high, so they never coincide.
  assign upd_ready = ~pending_q;
  assign accept    = upd_valid & ~pending_q;
  assign load      = wrap & pending_q;

  always_comb begin
    pending_d    = pending_q;
    shd_period_d = shd_period_q;
    shd_mode_d   = shd_mode_q;
    shd_duty_d   = shd_duty_q;
    act_period_d = act_period_q;
    act_mode_d   = act_mode_q;
    act_duty_d   = act_duty_q;

    if (accept) begin
      pending_d    = 1'b1;
      shd_period_d = upd_period;
      shd_mode_d   = upd_mode;
      shd_duty_d   = upd_duty;
    end

    if (load) begin
      pending_d    = 1'b0;
      act_period_d = shd_period_q;
      act_mode_d   = shd_mode_q;
      act_duty_d   = shd_duty_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q    <= 1'b0;
      // NOTE: the shadow bank is only read while pending is set, so its reset
      // is not functionally required; it is cleared anyway so an update that
      // was in flight at reset leaves no trace.
      shd_period_q <= '0;
      shd_mode_q   <= MODE_EDGE;
      shd_duty_q   <= '0;
      act_period_q <= '1;
      act_mode_q   <= MODE_EDGE;
      act_duty_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      shd_period_q <= shd_period_d;
      shd_mode_q   <= shd_mode_d;
      shd_duty_q   <= shd_duty_d;
      act_period_q <= act_period_d;
      act_mode_q   <= act_mode_d;
      act_duty_q   <= act_duty_d;
    end
  end

  assign duty_active = act_duty_q;

  // Per-channel compare: high while duty > cnt, giving a pulse anchored at
  // cnt == 0 (leading in edge mode, centred in centre mode).
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] duty;
    assign duty       = act_duty_q[duty_lsb(i, WIDTH) +: WIDTH];
    assign pwm_out[i] = en & (duty > cnt);
  end

  // cycle_start relies on the counter never sitting at 0 while heading down.
  assert property (@(posedge clk) disable iff (!rst) (cnt == '0) |-> (cnt_dir == DIR_UP));

endmodule : pwm_multi

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//   Directed bench for pwm_multi (WIDTH = 8, CHANNELS = 4). Inputs change and
//   outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_period;
  logic        upd_mode;
  logic [31:0] upd_duty;
  logic [3:0]  pwm_out;
  logic        cycle_start;
  logic [31:0] duty_active;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multi #(
    .WIDTH    (8),
    .CHANNELS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_period  (upd_period),
    .upd_mode    (upd_mode),
    .upd_duty    (upd_duty),
    .pwm_out     (pwm_out),
    .cycle_start (cycle_start),
    .duty_active (duty_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads a full configuration through the handshake with en held low, which
  // makes every edge a boundary: accept on one edge, load on the next.
  task automatic configure(input logic [7:0] p, input logic m, input logic [31:0] d);
    int guard;
    en    = 1'b0;
    guard = 0;
    while (upd_ready !== 1'b1 && guard < 600) begin
      step();
      guard++;
    end
    if (guard >= 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_ready_timeout: upd_ready=%b after %0d cycles, required 1", upd_ready, guard);
    end
    upd_valid  = 1'b1;
    upd_period = p;
    upd_mode   = m;
    upd_duty   = d;
    step();
    upd_valid = 1'b0;
    step();
    n_tests++;
    if (duty_active !== d) begin
      n_fail++;
      $display("FAIL cfg_duty_active: got %h required %h", duty_active, d);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    en         = 1'b1;
    upd_valid  = 1'b0;
    upd_period = 8'd0;
    upd_mode   = 1'b0;
    upd_duty   = 32'd0;
    #1 rst = 1'b0;
    #2;
    n_tests++;
    if (pwm_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pwm: got %b required 0000", pwm_out);
    end
    n_tests++;
    if (cycle_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle_start: got %b required 0", cycle_start);
    end
    n_tests++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_upd_ready: got %b required 1", upd_ready);
    end
    n_tests++;
    if (duty_active !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_duty_active: got %h required 0", duty_active);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (cycle_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_cycle_start: got %b required 1", cycle_start);
    end
    step();
    n_tests++;
    if (cycle_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt1_cycle_start: got %b required 0", cycle_start);
    end
  endtask

  task automatic test_edge();
    logic [3:0] exp_pwm;
    int c;
    configure(8'd9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd3});
    en = 1'b1;
    #1;
    for (int k = 0; k < 30; k++) begin
      c       = k % 10;
      exp_pwm = {c < 5, 1'b1, 1'b0, c < 3};
      n_tests++;
      if (pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL edge_pwm k=%0d: got %b required %b", k, pwm_out, exp_pwm);
      end
      n_tests++;
      if (cycle_start !== (c == 0)) begin
        n_fail++;
        $display("FAIL edge_cycle_start k=%0d: got %b required %b", k, cycle_start, c == 0);
      end
      step();
    end
  endtask

  task automatic test_centre();
    int cseq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    logic [3:0] exp_pwm;
    int c;
    configure(8'd4, 1'b1, {8'd5, 8'd0, 8'd1, 8'd2});
    en = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      c       = cseq[k % 8];
      exp_pwm = {1'b1, 1'b0, c < 1, c < 2};
      n_tests++;
      if (pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL centre_pwm k=%0d: got %b required %b", k, pwm_out, exp_pwm);
      end
      n_tests++;
      if (cycle_start !== (k % 8 == 0)) begin
        n_fail++;
        $display("FAIL centre_cycle_start k=%0d: got %b required %b", k, cycle_start, k % 8 == 0);
      end
      step();
    end
  endtask

  task automatic test_update_mid();
    configure(8'd9, 1'b0, {4{8'd3}});
    en = 1'b1;
    #1;
    n_tests++;
    if (cycle_start !== 1'b1) begin
      n_fail++;
      $display("FAIL upd_first_cycle_start: got %b required 1", cycle_start);
    end
    repeat (4) step();
    upd_valid  = 1'b1;
    upd_period = 8'd9;
    upd_mode   = 1'b0;
    upd_duty   = {4{8'd7}};
    n_tests++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL upd_ready_idle: got %b required 1", upd_ready);
    end
    step();
    n_tests++;
    if (upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL upd_ready_drop: got %b required 0", upd_ready);
    end
    upd_duty = {4{8'd1}};
    for (int k = 6; k <= 9; k++) begin
      step();
      n_tests++;
      if (upd_ready !== 1'b0 || duty_active !== {4{8'd3}} || cycle_start !== 1'b0) begin
        n_fail++;
        $display("FAIL upd_hold cnt=%0d: got ready=%b duty=%h cs=%b required ready=0 duty=03030303 cs=0",
                 k, upd_ready, duty_active, cycle_start);
      end
    end
    step();
    n_tests++;
    if (cycle_start !== 1'b1 || duty_active !== {4{8'd7}} || upd_ready !== 1'b1 || pwm_out !== 4'hF) begin
      n_fail++;
      $display("FAIL upd_boundary: got cs=%b duty=%h ready=%b pwm=%b required cs=1 duty=07070707 ready=1 pwm=1111",
               cycle_start, duty_active, upd_ready, pwm_out);
    end
    step();
    n_tests++;
    if (upd_ready !== 1'b0 || duty_active !== {4{8'd7}}) begin
      n_fail++;
      $display("FAIL upd_second_accept: got ready=%b duty=%h required ready=0 duty=07070707",
               upd_ready, duty_active);
    end
    upd_valid = 1'b0;
    repeat (6) step();
    n_tests++;
    if (pwm_out !== 4'h0) begin
      n_fail++;
      $display("FAIL upd_duty7_cnt7: got %b required 0000", pwm_out);
    end
    repeat (3) step();
    n_tests++;
    if (cycle_start !== 1'b1 || duty_active !== {4{8'd1}} || upd_ready !== 1'b1 || pwm_out !== 4'hF) begin
      n_fail++;
      $display("FAIL upd_second_load: got cs=%b duty=%h ready=%b pwm=%b required cs=1 duty=01010101 ready=1 pwm=1111",
               cycle_start, duty_active, upd_ready, pwm_out);
    end
    step();
    n_tests++;
    if (pwm_out !== 4'h0) begin
      n_fail++;
      $display("FAIL upd_duty1_cnt1: got %b required 0000", pwm_out);
    end
  endtask

  task automatic test_enable_low();
    logic [31:0] new_duty;
    new_duty = {8'd0, 8'd2, 8'd9, 8'd10};
    en = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 4'h0 || cycle_start !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low_immediate: got pwm=%b cs=%b required pwm=0000 cs=0", pwm_out, cycle_start);
    end
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        upd_valid  = 1'b1;
        upd_period = 8'd9;
        upd_mode   = 1'b0;
        upd_duty   = new_duty;
      end
      step();
      if (k == 5) begin
        upd_valid = 1'b0;
        n_tests++;
        if (upd_ready !== 1'b0 || duty_active !== {4{8'd1}}) begin
          n_fail++;
          $display("FAIL en_low_accept: got ready=%b duty=%h required ready=0 duty=01010101",
                   upd_ready, duty_active);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (upd_ready !== 1'b1 || duty_active !== new_duty) begin
          n_fail++;
          $display("FAIL en_low_load: got ready=%b duty=%h required ready=1 duty=%h",
                   upd_ready, duty_active, new_duty);
        end
      end
      n_tests++;
      if (pwm_out !== 4'h0 || cycle_start !== 1'b0) begin
        n_fail++;
        $display("FAIL en_low_hold k=%0d: got pwm=%b cs=%b required pwm=0000 cs=0", k, pwm_out, cycle_start);
      end
    end
    en = 1'b1;
    #1;
    n_tests++;
    if (cycle_start !== 1'b1 || pwm_out !== 4'b0111) begin
      n_fail++;
      $display("FAIL en_rise_cnt0: got cs=%b pwm=%b required cs=1 pwm=0111", cycle_start, pwm_out);
    end
    repeat (2) step();
    n_tests++;
    if (pwm_out !== 4'b0011) begin
      n_fail++;
      $display("FAIL en_rise_cnt2: got %b required 0011", pwm_out);
    end
    repeat (7) step();
    n_tests++;
    if (pwm_out !== 4'b0001 || cycle_start !== 1'b0) begin
      n_fail++;
      $display("FAIL en_rise_cnt9: got pwm=%b cs=%b required pwm=0001 cs=0", pwm_out, cycle_start);
    end
    step();
    n_tests++;
    if (cycle_start !== 1'b1) begin
      n_fail++;
      $display("FAIL en_rise_wrap: got %b required 1", cycle_start);
    end
  endtask

  task automatic test_period_zero();
    for (int m = 0; m < 2; m++) begin
      configure(8'd0, m[0], {8'd0, 8'd255, 8'd1, 8'd0});
      en = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (cycle_start !== 1'b1 || pwm_out !== 4'b0110) begin
          n_fail++;
          $display("FAIL p0 mode=%0d k=%0d: got cs=%b pwm=%b required cs=1 pwm=0110",
                   m, k, cycle_start, pwm_out);
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    configure(8'd9, 1'b0, {4{8'd6}});
    en = 1'b1;
    repeat (3) step();
    upd_valid  = 1'b1;
    upd_period = 8'd2;
    upd_mode   = 1'b1;
    upd_duty   = {4{8'd4}};
    step();
    upd_valid = 1'b0;
    n_tests++;
    if (upd_ready !== 1'b0 || pwm_out !== 4'hF) begin
      n_fail++;
      $display("FAIL rmid_before: got ready=%b pwm=%b required ready=0 pwm=1111", upd_ready, pwm_out);
    end
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 4'h0 || duty_active !== 32'd0 || upd_ready !== 1'b1 || cycle_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got pwm=%b duty=%h ready=%b cs=%b required pwm=0000 duty=0 ready=1 cs=0",
               pwm_out, duty_active, upd_ready, cycle_start);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (cycle_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_restart: got %b required 1", cycle_start);
    end
    step();
    n_tests++;
    if (cycle_start !== 1'b0 || upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_cnt1: got cs=%b ready=%b required cs=0 ready=1", cycle_start, upd_ready);
    end
    en = 1'b0;
    repeat (2) step();
    n_tests++;
    if (duty_active !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_shadow_discarded: got %h required 0", duty_active);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_centre();
    test_update_mid();
    test_enable_low();
    test_period_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pwm_multi
